// File: rtl/bitwise_logic_seq.sv
`default_nettype none
// ============================================================================
// Module   : bitwise_logic_seq
// Purpose  : Multi-cycle bitwise logic unit. Operands and opcode are latched
//            on an accepted start request, then processed SLICE bits per
//            cycle, least-significant slice first. Registered zero and parity
//            flags are accumulated as each slice of the result is written.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   WIDTH  : operand/result width (integer multiple of SLICE)
//   SLICE  : bits processed per cycle
// Ports
//   clk    in   1      clock, all state updates on the rising edge
//   rst    in   1      synchronous active-high reset, beats start
//   start  in   1      request, accepted in IDLE or DONE only
//   op     in   3      000 AND, 001 OR, 010 XOR, 011 NOR, 100 XNOR,
//                      101 NAND, 110 NOT a, 111 pass a
//   a      in   WIDTH  operand A, sampled at the accepting edge
//   b      in   WIDTH  operand B, sampled at the accepting edge
//   busy   out  1      high while processing slices
//   done   out  1      one-cycle pulse, result and flags final
//   result out  WIDTH  result register
//   zero   out  1      result == 0
//   parity out  1      XOR-reduction of result
// ============================================================================
module bitwise_logic_seq #(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             parity
);

  localparam int N  = WIDTH / SLICE;
  // Counter needs at least one bit even when there is a single slice.
  localparam int KW = (N > 1) ? $clog2(N) : 1;
  localparam logic [KW-1:0] C_K_LAST = KW'(N - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [KW-1:0]    r_k;
  logic [WIDTH-1:0] r_a_l;
  logic [WIDTH-1:0] r_b_l;
  logic [2:0]       r_op_l;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_result;
  logic             r_zero;
  logic             r_parity;

  logic [SLICE-1:0] w_a_slice;
  logic [SLICE-1:0] w_b_slice;
  logic [SLICE-1:0] w_slice;
  logic [WIDTH-1:0] w_result_next;
  logic             w_accept;

  // A new request is taken only between operations; start during RUN is
  // dropped rather than queued.
  assign w_accept = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));

  // Select slice k of the latched operands. A constant-index loop keeps every
  // part-select static, so the mux is a plain decoder on r_k.
  always_comb begin
    w_a_slice = '0;
    w_b_slice = '0;
    for (int i = 0; i < N; i++) begin
      if (r_k == KW'(i)) begin
        w_a_slice = r_a_l[i*SLICE +: SLICE];
        w_b_slice = r_b_l[i*SLICE +: SLICE];
      end
    end
  end

  // Bitwise function on the current slice.
  always_comb begin
    w_slice = '0;
    case (r_op_l)
      3'b000:  w_slice = w_a_slice & w_b_slice;
      3'b001:  w_slice = w_a_slice | w_b_slice;
      3'b010:  w_slice = w_a_slice ^ w_b_slice;
      3'b011:  w_slice = ~(w_a_slice | w_b_slice);
      3'b100:  w_slice = ~(w_a_slice ^ w_b_slice);
      3'b101:  w_slice = ~(w_a_slice & w_b_slice);
      3'b110:  w_slice = ~w_a_slice;
      default: w_slice = w_a_slice;
    endcase
  end

  // Result with slice k replaced; other slices keep their current contents.
  always_comb begin
    w_result_next = r_result;
    for (int i = 0; i < N; i++) begin
      if (r_k == KW'(i)) begin
        w_result_next[i*SLICE +: SLICE] = w_slice;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_k      <= '0;
      r_a_l    <= '0;
      r_b_l    <= '0;
      r_op_l   <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_result <= '0;
      r_zero   <= 1'b1;
      r_parity <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        // Accept from IDLE or DONE: latch operands and clear the result.
        r_state  <= ST_RUN;
        r_k      <= '0;
        r_a_l    <= a;
        r_b_l    <= b;
        r_op_l   <= op;
        r_busy   <= 1'b1;
        r_result <= '0;
        r_zero   <= 1'b1;
        r_parity <= 1'b0;
      end else begin
        case (r_state)
          ST_RUN: begin
            r_result <= w_result_next;
            r_zero   <= r_zero & (w_slice == '0);
            r_parity <= r_parity ^ (^w_slice);
            if (r_k == C_K_LAST) begin
              r_state <= ST_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_k     <= '0;
            end else begin
              r_k <= r_k + 1'b1;
            end
          end
          ST_DONE: begin
            // DONE lasts one cycle; without a new request fall back to IDLE.
            r_state <= ST_IDLE;
          end
          default: begin
            r_state <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign busy   = r_busy;
  assign done   = r_done;
  assign result = r_result;
  assign zero   = r_zero;
  assign parity = r_parity;

endmodule
`default_nettype wire

// File: tb/tb_bitwise_logic_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_bitwise_logic_seq
// Purpose  : Directed self-checking bench for bitwise_logic_seq. Instance u0
//            uses WIDTH=32/SLICE=8, instance u1 uses WIDTH=SLICE=32.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bitwise_logic_seq;

  logic        clk;
  logic        rst;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;

  logic        busy0, done0, zero0, parity0;
  logic [31:0] result0;
  logic        busy1, done1, zero1, parity1;
  logic [31:0] result1;

  int checks;
  int failures;

  bitwise_logic_seq #(.WIDTH(32), .SLICE(8)) u0 (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .busy   (busy0),
    .done   (done0),
    .result (result0),
    .zero   (zero0),
    .parity (parity0)
  );

  bitwise_logic_seq #(.WIDTH(32), .SLICE(32)) u1 (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .busy   (busy1),
    .done   (done1),
    .result (result1),
    .zero   (zero1),
    .parity (parity1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Pulse start for one edge, then count cycles until u0 raises done.
  task automatic run_op(input logic [2:0] o, input logic [31:0] av,
                        input logic [31:0] bv, output int cycles);
    op    = o;
    a     = av;
    b     = bv;
    start = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    cycles = 0;
    while (!done0 && cycles < 20) begin
      @(negedge clk);
      cycles++;
    end
  endtask

  int  n;
  bit  seen;

  initial begin
    checks   = 0;
    failures = 0;
    rst   = 1'b1;
    start = 1'b1;
    op    = 3'b010;
    a     = $urandom;
    b     = $urandom;

    // Reset held two cycles with start high.
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("rst_busy",   {31'd0, busy0},   32'd0);
      chk("rst_done",   {31'd0, done0},   32'd0);
      chk("rst_result", result0,          32'h0000_0000);
      chk("rst_zero",   {31'd0, zero0},   32'd1);
      chk("rst_parity", {31'd0, parity0}, 32'd0);
    end
    chk("rst_result_u1", result1, 32'h0000_0000);
    rst   = 1'b0;
    start = 1'b0;
    @(negedge clk);
    chk("post_rst_busy",   {31'd0, busy0}, 32'd0);
    chk("post_rst_zero",   {31'd0, zero0}, 32'd1);
    chk("post_rst_result", result0,        32'h0);

    // XOR with cycle-by-cycle observation.
    op    = 3'b010;
    a     = 32'hF0F0_1234;
    b     = 32'h0FF0_FFFF;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("xor_busy_e0", {31'd0, busy0}, 32'd1);
    @(negedge clk);
    chk("xor_partial0", result0, 32'h0000_00CB);
    chk("xor_done_e1",  {31'd0, done0}, 32'd0);
    @(negedge clk);
    chk("xor_done_e2",  {31'd0, done0}, 32'd0);
    @(negedge clk);
    chk("xor_done_e3",  {31'd0, done0}, 32'd0);
    chk("xor_busy_e3",  {31'd0, busy0}, 32'd1);
    @(negedge clk);
    chk("xor_done_e4",  {31'd0, done0},   32'd1);
    chk("xor_busy_e4",  {31'd0, busy0},   32'd0);
    chk("xor_result",   result0,          32'hFF00_EDCB);
    chk("xor_zero",     {31'd0, zero0},   32'd0);
    chk("xor_parity",   {31'd0, parity0}, 32'd1);
    @(negedge clk);
    chk("xor_done_e5",  {31'd0, done0}, 32'd0);
    chk("xor_hold",     result0,        32'hFF00_EDCB);

    // AND then OR on the same operands.
    run_op(3'b000, 32'hAAAA_AAAA, 32'h5555_5555, n);
    chk("and_latency", n,                  32'd4);
    chk("and_result",  result0,            32'h0000_0000);
    chk("and_zero",    {31'd0, zero0},     32'd1);
    chk("and_parity",  {31'd0, parity0},   32'd0);
    run_op(3'b001, 32'hAAAA_AAAA, 32'h5555_5555, n);
    chk("or_latency",  n,                  32'd4);
    chk("or_result",   result0,            32'hFFFF_FFFF);
    chk("or_zero",     {31'd0, zero0},     32'd0);
    chk("or_parity",   {31'd0, parity0},   32'd0);
    @(negedge clk);

    // Start held high: operand change mid-RUN, back-to-back accept.
    op    = 3'b111;
    a     = 32'hCAFE_F00D;
    b     = 32'h1111_1111;
    start = 1'b1;
    @(negedge clk);          // E0 passed
    @(negedge clk);          // E1
    @(negedge clk);          // E2
    a = 32'h1234_5678;
    n = 0;
    while (!done0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("b2b_first_done", {31'd0, done0},   32'd1);
    chk("b2b_first",      result0,          32'hCAFE_F00D);
    chk("b2b_first_par",  {31'd0, parity0}, 32'd0);
    n = 0;
    @(negedge clk);
    n++;
    while (!done0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    chk("b2b_spacing",    n,                32'd5);
    chk("b2b_second",     result0,          32'h1234_5678);
    chk("b2b_second_par", {31'd0, parity0}, 32'd1);
    @(negedge clk);
    @(negedge clk);
    chk("b2b_idle_busy",  {31'd0, busy0},   32'd0);

    // Reset after two XOR slices aborts the operation.
    op    = 3'b010;
    a     = 32'hF0F0_1234;
    b     = 32'h0FF0_FFFF;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy",   {31'd0, busy0},   32'd0);
    chk("abort_done",   {31'd0, done0},   32'd0);
    chk("abort_result", result0,          32'h0);
    chk("abort_zero",   {31'd0, zero0},   32'd1);
    chk("abort_parity", {31'd0, parity0}, 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done0) seen = 1'b1;
    end
    chk("abort_no_done", {31'd0, seen}, 32'd0);
    run_op(3'b010, 32'hF0F0_1234, 32'h0FF0_FFFF, n);
    chk("fresh_latency", n,       32'd4);
    chk("fresh_result",  result0, 32'hFFFF_FFFF & 32'hFF00_EDCB);
    @(negedge clk);

    // Single-slice instance: NOT a.
    op    = 3'b110;
    a     = 32'h0000_00FF;
    b     = 32'hDEAD_BEEF;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("n1_busy_e0",  {31'd0, busy1},   32'd1);
    chk("n1_done_e0",  {31'd0, done1},   32'd0);
    @(negedge clk);
    chk("n1_done_e1",  {31'd0, done1},   32'd1);
    chk("n1_result",   result1,          32'hFFFF_FF00);
    chk("n1_zero",     {31'd0, zero1},   32'd0);
    chk("n1_parity",   {31'd0, parity1}, 32'd0);
    @(negedge clk);
    chk("n1_done_e2",  {31'd0, done1},   32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/bitwise_logic_seq.md
# bitwise_logic_seq

Parametrised, multi-cycle bitwise logic unit. It is the sequential successor to the team's fixed-width combinational XOR stage. Operands are latched on a start handshake and processed SLICE bits per cycle, LSB slice first, under one of eight bitwise operations. The unit also produces registered zero and parity flags. It sits beside the ALU datapath, where narrow-slice area matters more than single-cycle latency.

## Interface
- WIDTH, 32, operand/result width; must be an integer multiple of SLICE.
- SLICE, 8, bits processed per cycle; N = WIDTH/SLICE slices (N ≥ 1).
- clk  in  1  sole clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request; accepted only when state is IDLE or DONE.
- op  in  3  operation: 000 AND, 001 OR, 010 XOR, 011 NOR, 100 XNOR, 101 NAND, 110 NOT a (b ignored), 111 pass a.
- a  in  WIDTH  operand A, sampled only at the accepting edge.
- b  in  WIDTH  operand B, sampled only at the accepting edge.
- busy  out  1  high while state is RUN.
- done  out  1  one-cycle pulse; result/zero/parity final.
- result  out  WIDTH  result register.
- zero  out  1  result == 0 (accumulated per slice).
- parity  out  1  XOR-reduction of result (accumulated per slice).

## Operation
- States:
  - IDLE: initial and reset state. IDLE→RUN on start.
  - RUN: slice counter k = 0..N-1. At each edge, write result[k*SLICE +: SLICE] = f(op, a_l slice k, b_l slice k), then k++. When k = N-1 is written, RUN→DONE.
  - DONE: exactly one cycle. DONE→RUN if start is high, else DONE→IDLE.
- Accept edge:
  - Latch a, b and op into internal registers a_l, b_l, op_l.
  - Clear result to 0, set zero=1 and parity=0, and set k=0.
  - Input changes after the accept edge have no effect on the operation in flight.
- Flag accumulation at each slice write: zero ← zero & (slice==0); parity ← parity ^ ^slice.
- start in RUN is ignored; it is neither queued nor does it cause an abort.
- result is partially updated during RUN. It is only defined as final in the done cycle. result, zero and parity hold their values until the next accept edge or reset.
- rst has priority over everything, including start:
  - State goes to IDLE, k=0, busy=0, done=0, result=0, zero=1, parity=0.
  - Reset mid-RUN aborts the operation; no done pulse follows.
- N=1 (SLICE=WIDTH): RUN lasts one cycle.

## Timing
- Reset values: busy=0, done=0, result=0, zero=1, parity=0, state IDLE.
- Let E0 be the edge that samples start high in IDLE or DONE.
  - busy is high from after E0 until after E_N.
  - The slice k write occurs at edge E_(k+1).
  - done is high for the single cycle between E_N and E_(N+1).
  - Latency from accept edge to done = N cycles.
- Back-to-back operation: holding start high accepts a new operation at every DONE edge. Throughput is one result per N+1 cycles, and done pulses never merge.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Reset: hold rst=1 for 2 cycles with start=1 and random a/b -> busy=0, done=0, result=0x00000000, zero=1, parity=0 throughout and after release.
- XOR, WIDTH=32, SLICE=8, a=0xF0F01234, b=0x0FF0FFFF:
  - done exactly 4 cycles after the accept edge.
  - result=0xFF00EDCB, zero=0, parity=1.
  - Mid-RUN partial result after slice 0 is 0x000000CB.
- AND a=0xAAAAAAAA, b=0x55555555 -> result=0x00000000, zero=1, parity=0. Then re-pulse start with op=OR on the same operands -> result=0xFFFFFFFF, zero=0, parity=0.
- Hold start=1 continuously:
  - Change a to 0x12345678 two cycles into RUN -> the first result uses the original a.
  - The second operation is accepted at the DONE edge and uses the then-current a.
  - done pulses are 5 cycles apart.
- Assert rst for 1 cycle after 2 slices of an XOR -> next cycle: state IDLE, result=0, zero=1, no done pulse. A fresh start afterwards completes normally.
- SLICE=WIDTH=32, op=NOT, a=0x000000FF -> done 1 cycle after the accept edge, result=0xFFFFFF00, zero=0, parity=0.
